cpe_frame_sequencer: RTL and testbench

Sits between the ZF equalizer output and cpe_tracker in the 2x2 OFDM receive chain. It forwards ZF samples into the tracker and counts them into 64-sample symbols. When a frame ends it inserts one zero-valued flush symbol, so the tracker's ping-pong bank releases the last real symbol. Each tracker output symbol and phase-error pulse is tagged real or flush; flush results are suppressed and real outputs are marked with frame and symbol boundaries.

---
 rtl/cpe_frame_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_cpe_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpe_frame_sequencer.sv
// Frame sequencer between the ZF equalizer and cpe_tracker: forwards samples, appends one zero flush
// symbol per frame and tags tracker outputs. Optional idle timeout enabled by `define SEQ_TIMEOUT_EN.
module cpe_frame_sequencer #(
   parameter int DATA_W    = 16,
   parameter int PHASE_W   = 16,
   parameter int NFFT      = 64,
   parameter int TAG_DEPTH = 4,
   parameter int SYM_W     = 8,
   parameter int TIMEOUT   = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic                      s_last,
   input  logic signed [DATA_W-1:0]  s_X1_re,
   input  logic signed [DATA_W-1:0]  s_X1_im,
   input  logic signed [DATA_W-1:0]  s_X2_re,
   input  logic signed [DATA_W-1:0]  s_X2_im,
   output logic                      trk_in_valid,
   output logic signed [DATA_W-1:0]  trk_X1_re,
   output logic signed [DATA_W-1:0]  trk_X1_im,
   output logic signed [DATA_W-1:0]  trk_X2_re,
   output logic signed [DATA_W-1:0]  trk_X2_im,
   input  logic                      trk_out_valid,
   input  logic signed [DATA_W-1:0]  trk_X1c_re,
   input  logic signed [DATA_W-1:0]  trk_X1c_im,
   input  logic signed [DATA_W-1:0]  trk_X2c_re,
   input  logic signed [DATA_W-1:0]  trk_X2c_im,
   input  logic                      trk_phase_err_valid,
   input  logic signed [PHASE_W-1:0] trk_phase_err,
   output logic                      m_valid,
   output logic signed [DATA_W-1:0]  m_X1_re,
   output logic signed [DATA_W-1:0]  m_X1_im,
   output logic signed [DATA_W-1:0]  m_X2_re,
   output logic signed [DATA_W-1:0]  m_X2_im,
   output logic                      m_sof,
   output logic                      m_eos,
   output logic                      m_eof,
   output logic [SYM_W-1:0]          m_sym_idx,
   output logic                      m_phase_err_valid,
   output logic signed [PHASE_W-1:0] m_phase_err,
   output logic                      err_short,
   output logic                      err_ovf,
`ifdef SEQ_TIMEOUT_EN
   output logic                      err_timeout,
`endif
   output logic                      busy
);

   localparam int CNT_W = $clog2(NFFT);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NFFT - 1);
   localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(TAG_DEPTH);
   localparam logic [PTR_W:0]   ROOM_C   = (PTR_W + 1)'(TAG_DEPTH - 2);

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_PAD, S_FLUSH} state_t;

   typedef struct packed {
      logic             is_real;
      logic             first;
      logic             last;
      logic [SYM_W-1:0] sym_idx;
   } tag_t;

   function automatic logic [SYM_W-1:0] sat_inc(input logic [SYM_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             first_q, first_d;
   logic [SYM_W-1:0] sym_idx_q, sym_idx_d;
   logic             err_short_q, err_short_d;
   logic             err_ovf_q, err_ovf_d;
   logic             rdy_en_q;

   // Tag FIFOs: data tags carry the full tag, phase tags only need the real/flush bit
   tag_t             dmem_q [TAG_DEPTH];
   logic             pmem_q [TAG_DEPTH];
   logic [PTR_W:0]   dwr_q, dwr_d, drd_q, drd_d;
   logic [PTR_W:0]   pwr_q, pwr_d, prd_q, prd_d;
   logic [PTR_W:0]   d_cnt, p_cnt;
   logic             d_empty, d_full, p_empty, p_full;
   logic             d_pop, p_pop, d_push_ok, p_push_ok;
   tag_t             d_head;
   logic             p_head;

   logic             push;
   tag_t             push_tag;
   logic             accept, in_vld, wrap;

   logic                      m_valid_q, m_valid_d;
   logic                      m_sof_q, m_sof_d, m_eos_q, m_eos_d, m_eof_q, m_eof_d;
   logic [SYM_W-1:0]          m_sym_idx_q, m_sym_idx_d;
   logic signed [DATA_W-1:0]  m_x1r_q, m_x1r_d, m_x1i_q, m_x1i_d;
   logic signed [DATA_W-1:0]  m_x2r_q, m_x2r_d, m_x2i_q, m_x2i_d;
   logic                      m_pe_vld_q, m_pe_vld_d;
   logic signed [PHASE_W-1:0] m_pe_q, m_pe_d;
   logic                      out_take, out_real, ph_take;

`ifdef SEQ_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic              err_timeout_q, err_timeout_d;
   logic              rewrite;
   logic [PTR_W-1:0]  last_idx;
`endif

   assign d_cnt   = dwr_q - drd_q;
   assign p_cnt   = pwr_q - prd_q;
   assign d_empty = (d_cnt == '0);
   assign p_empty = (p_cnt == '0);
   assign d_full  = (d_cnt == DEPTH_C);
   assign p_full  = (p_cnt == DEPTH_C);
   assign d_head  = dmem_q[drd_q[PTR_W-1:0]];
   assign p_head  = pmem_q[prd_q[PTR_W-1:0]];

   // Input side needs room for a real tag and the flush tag that may follow it
   assign s_ready = rdy_en_q & ((state_q == S_IDLE) | (state_q == S_PASS))
                  & (d_cnt <= ROOM_C) & (p_cnt <= ROOM_C);
   assign accept  = s_valid & s_ready;
   assign in_vld  = accept | (state_q == S_PAD) | (state_q == S_FLUSH);
   assign wrap    = in_vld & (in_cnt_q == CNT_LAST);

   assign trk_in_valid = in_vld;
   assign trk_X1_re    = accept ? s_X1_re : '0;
   assign trk_X1_im    = accept ? s_X1_im : '0;
   assign trk_X2_re    = accept ? s_X2_re : '0;
   assign trk_X2_im    = accept ? s_X2_im : '0;

   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      first_d     = first_q;
      sym_idx_d   = sym_idx_q;
      err_short_d = err_short_q;
      push        = 1'b0;
      push_tag    = '0;
`ifdef SEQ_TIMEOUT_EN
      rewrite       = 1'b0;
      err_timeout_d = err_timeout_q;
      idle_cnt_d    = ((state_q == S_PASS) && !s_valid) ? idle_cnt_q + 1'b1 : '0;
      last_idx      = dwr_q[PTR_W-1:0] - 1'b1;
`endif
      if (in_vld) in_cnt_d = in_cnt_q + 1'b1;

      case (state_q)
         S_IDLE, S_PASS: begin
            if (accept) begin
               state_d = S_PASS;
               if (s_last) begin
                  if (wrap) begin
                     state_d = S_FLUSH;
                  end else begin
                     state_d     = S_PAD;
                     err_short_d = 1'b1;
                  end
               end
            end
         end
         S_PAD:   if (wrap) state_d = S_FLUSH;
         S_FLUSH: if (wrap) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

`ifdef SEQ_TIMEOUT_EN
      // A stalled frame is closed as if s_last had arrived; an already complete symbol gets its tag marked last
      if ((state_q == S_PASS) && !s_valid && (idle_cnt_q == IDLE_LAST)) begin
         err_timeout_d = 1'b1;
         if (in_cnt_q != '0) begin
            state_d = S_PAD;
         end else begin
            state_d = S_FLUSH;
            rewrite = 1'b1;
         end
      end
`endif

      if (wrap) begin
         push = 1'b1;
         if (state_q != S_FLUSH) begin
            push_tag  = {1'b1, first_q, (state_d == S_FLUSH), sym_idx_q};
            first_d   = 1'b0;
            sym_idx_d = sat_inc(sym_idx_q);
         end
      end
      if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
         first_d   = 1'b1;
         sym_idx_d = '0;
      end
   end

   always_comb begin
      out_take  = trk_out_valid & ~d_empty;
      out_real  = out_take & d_head.is_real;
      d_pop     = out_take & (out_cnt_q == CNT_LAST);
      ph_take   = trk_phase_err_valid & ~p_empty;
      p_pop     = ph_take;
      d_push_ok = push & (~d_full | d_pop);
      p_push_ok = push & (~p_full | p_pop);

      out_cnt_d = out_take ? out_cnt_q + 1'b1 : out_cnt_q;
      dwr_d     = d_push_ok ? dwr_q + 1'b1 : dwr_q;
      pwr_d     = p_push_ok ? pwr_q + 1'b1 : pwr_q;
      drd_d     = d_pop ? drd_q + 1'b1 : drd_q;
      prd_d     = p_pop ? prd_q + 1'b1 : prd_q;
      err_ovf_d = err_ovf_q | (push & d_full & ~d_pop) | (push & p_full & ~p_pop)
                | (trk_out_valid & d_empty);

      m_valid_d   = out_real;
      m_sof_d     = out_real & d_head.first & (out_cnt_q == '0);
      m_eos_d     = out_real & (out_cnt_q == CNT_LAST);
      m_eof_d     = m_eos_d & d_head.last;
      m_sym_idx_d = out_real ? d_head.sym_idx : m_sym_idx_q;
      m_x1r_d     = out_real ? trk_X1c_re : m_x1r_q;
      m_x1i_d     = out_real ? trk_X1c_im : m_x1i_q;
      m_x2r_d     = out_real ? trk_X2c_re : m_x2r_q;
      m_x2i_d     = out_real ? trk_X2c_im : m_x2i_q;
      m_pe_vld_d  = ph_take & p_head;
      m_pe_d      = (ph_take & p_head) ? trk_phase_err : m_pe_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         first_q     <= 1'b1;
         sym_idx_q   <= '0;
         err_short_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         rdy_en_q    <= 1'b0;
         dwr_q       <= '0;
         drd_q       <= '0;
         pwr_q       <= '0;
         prd_q       <= '0;
         m_valid_q   <= 1'b0;
         m_sof_q     <= 1'b0;
         m_eos_q     <= 1'b0;
         m_eof_q     <= 1'b0;
         m_sym_idx_q <= '0;
         m_x1r_q     <= '0;
         m_x1i_q     <= '0;
         m_x2r_q     <= '0;
         m_x2i_q     <= '0;
         m_pe_vld_q  <= 1'b0;
         m_pe_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         first_q     <= first_d;
         sym_idx_q   <= sym_idx_d;
         err_short_q <= err_short_d;
         err_ovf_q   <= err_ovf_d;
         rdy_en_q    <= 1'b1;
         dwr_q       <= dwr_d;
         drd_q       <= drd_d;
         pwr_q       <= pwr_d;
         prd_q       <= prd_d;
         m_valid_q   <= m_valid_d;
         m_sof_q     <= m_sof_d;
         m_eos_q     <= m_eos_d;
         m_eof_q     <= m_eof_d;
         m_sym_idx_q <= m_sym_idx_d;
         m_x1r_q     <= m_x1r_d;
         m_x1i_q     <= m_x1i_d;
         m_x2r_q     <= m_x2r_d;
         m_x2i_q     <= m_x2i_d;
         m_pe_vld_q  <= m_pe_vld_d;
         m_pe_q      <= m_pe_d;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q    <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         idle_cnt_q    <= idle_cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end
   assign err_timeout = err_timeout_q;
`endif

   always_ff @(posedge clk) begin
      if (d_push_ok) dmem_q[dwr_q[PTR_W-1:0]] <= push_tag;
      if (p_push_ok) pmem_q[pwr_q[PTR_W-1:0]] <= push_tag.is_real;
`ifdef SEQ_TIMEOUT_EN
      if (rewrite && !d_empty) dmem_q[last_idx].last <= 1'b1;
`endif
   end

   assign m_valid           = m_valid_q;
   assign m_X1_re           = m_x1r_q;
   assign m_X1_im           = m_x1i_q;
   assign m_X2_re           = m_x2r_q;
   assign m_X2_im           = m_x2i_q;
   assign m_sof             = m_sof_q;
   assign m_eos             = m_eos_q;
   assign m_eof             = m_eof_q;
   assign m_sym_idx         = m_sym_idx_q;
   assign m_phase_err_valid = m_pe_vld_q;
   assign m_phase_err       = m_pe_q;
   assign err_short         = err_short_q;
   assign err_ovf           = err_ovf_q;
   assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpe_frame_sequencer.sv
// Randomized bench for cpe_frame_sequencer with a ping-pong tracker stand-in and a queue-based
// reference built from each frame's padded sample list.
module tb_cpe_frame_sequencer;
   localparam int DATA_W  = 16;
   localparam int PHASE_W = 16;
   localparam int NFFT    = 64;
   localparam int SYM_W   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic s_valid, s_ready, s_last;
   logic [DATA_W-1:0] s_X1_re, s_X1_im, s_X2_re, s_X2_im;
   logic trk_in_valid;
   logic [DATA_W-1:0] trk_X1_re, trk_X1_im, trk_X2_re, trk_X2_im;
   logic trk_out_valid;
   logic [DATA_W-1:0] trk_X1c_re, trk_X1c_im, trk_X2c_re, trk_X2c_im;
   logic trk_phase_err_valid;
   logic [PHASE_W-1:0] trk_phase_err;
   logic m_valid, m_sof, m_eos, m_eof, m_phase_err_valid;
   logic [DATA_W-1:0] m_X1_re, m_X1_im, m_X2_re, m_X2_im;
   logic [SYM_W-1:0] m_sym_idx;
   logic [PHASE_W-1:0] m_phase_err;
   logic err_short, err_ovf, busy;
`ifdef SEQ_TIMEOUT_EN
   logic err_timeout;
`endif

   cpe_frame_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .s_X1_re(s_X1_re), .s_X1_im(s_X1_im), .s_X2_re(s_X2_re), .s_X2_im(s_X2_im),
      .trk_in_valid(trk_in_valid),
      .trk_X1_re(trk_X1_re), .trk_X1_im(trk_X1_im), .trk_X2_re(trk_X2_re), .trk_X2_im(trk_X2_im),
      .trk_out_valid(trk_out_valid),
      .trk_X1c_re(trk_X1c_re), .trk_X1c_im(trk_X1c_im), .trk_X2c_re(trk_X2c_re), .trk_X2c_im(trk_X2c_im),
      .trk_phase_err_valid(trk_phase_err_valid), .trk_phase_err(trk_phase_err),
      .m_valid(m_valid),
      .m_X1_re(m_X1_re), .m_X1_im(m_X1_im), .m_X2_re(m_X2_re), .m_X2_im(m_X2_im),
      .m_sof(m_sof), .m_eos(m_eos), .m_eof(m_eof), .m_sym_idx(m_sym_idx),
      .m_phase_err_valid(m_phase_err_valid), .m_phase_err(m_phase_err),
      .err_short(err_short), .err_ovf(err_ovf),
`ifdef SEQ_TIMEOUT_EN
      .err_timeout(err_timeout),
`endif
      .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Tracker stand-in: symbol k is replayed one cycle after each input sample of symbol k+1,
   // and its phase error (sample 0 X1_re) is strobed with the first replayed sample.
   logic [63:0] bank_in  [NFFT];
   logic [63:0] bank_out [NFFT];
   int  tidx;
   logic have;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tidx <= 0;
         have <= 1'b0;
         trk_out_valid <= 1'b0;
         trk_phase_err_valid <= 1'b0;
         trk_phase_err <= '0;
         {trk_X1c_re, trk_X1c_im, trk_X2c_re, trk_X2c_im} <= '0;
      end else begin
         trk_out_valid <= 1'b0;
         trk_phase_err_valid <= 1'b0;
         if (trk_in_valid) begin
            if (have) begin
               trk_out_valid <= 1'b1;
               {trk_X1c_re, trk_X1c_im, trk_X2c_re, trk_X2c_im} <= bank_out[tidx];
               if (tidx == 0) begin
                  trk_phase_err_valid <= 1'b1;
                  trk_phase_err <= bank_out[0][63:48];
               end
            end
            bank_in[tidx] <= {trk_X1_re, trk_X1_im, trk_X2_re, trk_X2_im};
            if (tidx == NFFT - 1) begin
               for (int k = 0; k < NFFT - 1; k++) bank_out[k] <= bank_in[k];
               bank_out[NFFT-1] <= {trk_X1_re, trk_X1_im, trk_X2_re, trk_X2_im};
               have <= 1'b1;
               tidx <= 0;
            end else begin
               tidx <= tidx + 1;
            end
         end
      end
   end

   // Reference: {data, sof, eos, eof, sym_idx} per expected real output sample
   logic [74:0]        exp_q[$];
   logic [PHASE_W-1:0] exp_ph[$];
   int n_in, n_nrdy;

   always @(negedge clk) begin
      if (rst_n) begin
         if (trk_in_valid) n_in++;
         if (!s_ready) n_nrdy++;
         if (m_valid) begin
            if (exp_q.size() == 0) chk("m_valid_unexpected", 128'(m_valid), 128'(0));
            else chk("m_sample", 128'({m_X1_re, m_X1_im, m_X2_re, m_X2_im, m_sof, m_eos, m_eof, m_sym_idx}),
                     128'(exp_q.pop_front()));
         end
         if (m_phase_err_valid) begin
            if (exp_ph.size() == 0) chk("m_phase_unexpected", 128'(m_phase_err_valid), 128'(0));
            else chk("m_phase_err", 128'(m_phase_err), 128'(exp_ph.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_frame(input int len, input int gap, input bit with_last, input bit with_ref);
      logic [63:0] fr[$];
      logic [63:0] d;
      logic [SYM_W-1:0] symv;
      int p, i, cyc;
      bit acc;
      for (int k = 0; k < len; k++) fr.push_back({$urandom(), $urandom()});
      if (with_ref) begin
         p = ((len + NFFT - 1) / NFFT) * NFFT;
         for (int j = 0; j < p; j++) begin
            d = (j < len) ? fr[j] : 64'd0;
            symv = (j / NFFT > 255) ? 8'd255 : 8'(j / NFFT);
            exp_q.push_back({d, (j == 0), (j % NFFT == NFFT - 1), (j == p - 1), symv});
            if (j % NFFT == 0) exp_ph.push_back(d[63:48]);
         end
      end
      i = 0;
      cyc = 0;
      while (i < len && cyc < len * 4 + 1000) begin
         s_valid = ($urandom_range(99) >= gap);
         {s_X1_re, s_X1_im, s_X2_re, s_X2_im} = fr[i];
         s_last = with_last && (i == len - 1);
         @(negedge clk);
         acc = s_valid && s_ready;
         step();
         if (acc) i++;
         cyc++;
      end
      if (i < len) chk("drive_stalled", 128'(i), 128'(len));
      s_valid = 1'b0;
      s_last = 1'b0;
      {s_X1_re, s_X1_im, s_X2_re, s_X2_im} = '0;
   endtask

   task automatic wait_idle(input string tag);
      int cyc;
      cyc = 0;
      while (busy && cyc < 3000) begin
         step();
         cyc++;
      end
      if (busy) chk({tag, "_idle_timeout"}, 128'(busy), 128'(0));
      repeat (4) step();
      chk({tag, "_data_drained"}, 128'(exp_q.size()), 128'(0));
      chk({tag, "_phase_drained"}, 128'(exp_ph.size()), 128'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      s_valid = 1'b0;
      s_last = 1'b0;
      {s_X1_re, s_X1_im, s_X2_re, s_X2_im} = '0;
      #1;
      chk("reset_outputs", 128'({m_valid, m_sof, m_eos, m_eof, m_sym_idx, m_X1_re, m_phase_err_valid,
                                 m_phase_err, err_short, err_ovf, busy, s_ready, trk_in_valid}), 128'(0));
      repeat (3) step();
      rst_n = 1'b1;
      repeat (3) step();

      // Two-symbol contiguous frame
      n_in = 0;
      n_nrdy = 0;
      drive_frame(2 * NFFT, 0, 1'b1, 1'b1);
      wait_idle("two_sym");
      chk("two_sym_in_cycles", 128'(n_in), 128'(3 * NFFT));
      chk("two_sym_ready_low", 128'(n_nrdy), 128'(NFFT));
      chk("two_sym_no_short", 128'(err_short), 128'(0));

      // Short frame: s_last on sample 40 of symbol 0
      drive_frame(41, 0, 1'b1, 1'b1);
      wait_idle("short");
      chk("short_err_short", 128'(err_short), 128'(1));

      // Reset during PASS after 30 samples
      drive_frame(30, 0, 1'b0, 1'b0);
      chk("mid_busy", 128'(busy), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs", 128'({m_valid, m_sof, m_eos, m_eof, m_sym_idx, m_X1_re, m_phase_err_valid,
                                     err_short, err_ovf, busy, s_ready, trk_in_valid}), 128'(0));
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      drive_frame(2 * NFFT, 0, 1'b1, 1'b1);
      wait_idle("post_reset");

      // Back-to-back frames, the second a single symbol
      drive_frame(2 * NFFT, 0, 1'b1, 1'b1);
      drive_frame(NFFT, 0, 1'b1, 1'b1);
      wait_idle("b2b");

      // 50% valid gaps on a full-length frame
      n_nrdy = 0;
      drive_frame(3 * NFFT, 50, 1'b1, 1'b1);
      wait_idle("gaps");
      chk("gaps_ready_low", 128'(n_nrdy), 128'(NFFT));

      // Random lengths with gaps, back to back
      for (int f = 0; f < 3; f++) drive_frame($urandom_range(1, 3 * NFFT), 30, 1'b1, 1'b1);
      wait_idle("rand");

      // Symbol index saturation
      drive_frame(258 * NFFT, 0, 1'b1, 1'b1);
      wait_idle("sat");

`ifdef SEQ_TIMEOUT_EN
      drive_frame(11, 0, 1'b0, 1'b1);
      wait_idle("timeout");
      chk("timeout_flag", 128'(err_timeout), 128'(1));
`endif

      chk("no_overflow", 128'(err_ovf), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
